// File: rtl/sprite_draw_control_pkg.sv
// sprite_draw_control_pkg: screen geometry, colours and FSM encoding for the sprite draw controller
package sprite_draw_control_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PLAYER_WIDTH = 3;
  localparam logic [2:0] BG_DEFAULT = 3'b000;
  localparam logic [2:0] PLAYER_DEFAULT = 3'b010;
  localparam logic [2:0] HIT_DEFAULT = 3'b110;
  localparam logic [2:0] ENEMY_DEFAULT = 3'b100;
  typedef enum logic [2:0] {IDLE, ERASE_P, DRAW_P, ERASE_E, PUB_E, WAIT_E, DRAW_E} state_e;
  function automatic logic is_scan(state_e s);
    return s inside {ERASE_P, DRAW_P, ERASE_E, DRAW_E};
  endfunction
endpackage

// File: rtl/sprite_draw_control_if.sv
// sprite_draw_control_if: move requests from player/enemy control in, pixel writes and publish strobe out
interface sprite_draw_control_if;
  logic       player_move;
  logic [7:0] playerX;
  logic [6:0] playerY;
  logic       player_hit;
  logic       enemy_move;
  logic [7:0] enemyX;
  logic [6:0] enemyY;
  logic [2:0] enemy_width;
  logic       output_pos;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  modport master (
    output player_move, playerX, playerY, player_hit, enemy_move, enemyX, enemyY, enemy_width,
    input  output_pos, x, y, colour, plot, busy
  );
  modport slave (
    input  player_move, playerX, playerY, player_hit, enemy_move, enemyX, enemyY, enemy_width,
    output output_pos, x, y, colour, plot, busy
  );
endinterface

// File: rtl/sprite_draw_control_box_scanner.sv
// sprite_draw_control_box_scanner: row-major w x w pixel walk with off-screen clipping
module sprite_draw_control_box_scanner
  import sprite_draw_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [2:0] w,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       in_bounds,
  output logic       last
);
  logic [2:0] dx_q, dx_d, dy_q, dy_d;
  logic [8:0] sx;
  logic [7:0] sy;
  logic       row_end;
  always_comb begin
    row_end = dx_q == w - 3'd1;
    last = w == 3'd0 || (row_end && dy_q == w - 3'd1);
    dx_d = start ? 3'd0 : row_end ? 3'd0 : dx_q + 3'd1;
    dy_d = start ? 3'd0 : row_end ? dy_q + 3'd1 : dy_q;
    sx = {1'b0, base_x} + {6'd0, dx_q};
    sy = {1'b0, base_y} + {5'd0, dy_q};
    in_bounds = w != 3'd0 && sx < 9'(SCREEN_W) && sy < 8'(SCREEN_H);
    x = sx[7:0];
    y = sy[6:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
endmodule

// File: rtl/sprite_draw_control.sv
// sprite_draw_control: turns player/enemy move pulses into erase-then-redraw pixel streams,
// publishing the enemy position only once its old sprite is gone
module sprite_draw_control
  import sprite_draw_control_pkg::*;
#(
  parameter int         PLAYER_W      = PLAYER_WIDTH,
  parameter logic [2:0] BG_COLOUR     = BG_DEFAULT,
  parameter logic [2:0] PLAYER_COLOUR = PLAYER_DEFAULT,
  parameter logic [2:0] HIT_COLOUR    = HIT_DEFAULT,
  parameter logic [2:0] ENEMY_COLOUR  = ENEMY_DEFAULT
) (
  input logic clk,
  input logic reset,
  sprite_draw_control_if.slave bus
);
  state_e     state_q, state_d;
  logic       pend_p_q, pend_p_d, pend_e_q, pend_e_d;
  logic       valid_p_q, valid_p_d, valid_e_q, valid_e_d;
  logic [7:0] lpx_q, lpx_d, ex_q, ex_d;
  logic [6:0] lpy_q, lpy_d, ey_q, ey_d;
  logic [2:0] ew_q, ew_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, pos_q, pos_d;
  logic       is_player, start, leave, ld_e, in_bounds, last;
  logic [7:0] sx;
  logic [6:0] sy;
  assign is_player = state_q inside {ERASE_P, DRAW_P};
  sprite_draw_control_box_scanner u_scan (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_x(is_player ? lpx_q : ex_q),
    .base_y(is_player ? lpy_q : ey_q),
    .w(is_player ? 3'(PLAYER_W) : ew_q),
    .x(sx),
    .y(sy),
    .in_bounds(in_bounds),
    .last(last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pend_p_q ? (valid_p_q ? ERASE_P : DRAW_P)
                       : pend_e_q ? (valid_e_q ? ERASE_E : PUB_E) : IDLE;
      ERASE_P: state_d = last ? DRAW_P : ERASE_P;
      DRAW_P:  state_d = last ? IDLE : DRAW_P;
      ERASE_E: state_d = last ? PUB_E : ERASE_E;
      PUB_E:   state_d = WAIT_E;
      WAIT_E:  state_d = DRAW_E;
      DRAW_E:  state_d = last ? IDLE : DRAW_E;
      default: state_d = IDLE;
    endcase
    start = is_scan(state_d) && state_d != state_q;
    leave = state_q == IDLE && state_d != IDLE;
    // a pulse on the leaving edge re-arms the flag for one more redraw
    pend_p_d = bus.player_move || (pend_p_q && !(leave && state_d inside {ERASE_P, DRAW_P}));
    pend_e_d = bus.enemy_move || (pend_e_q && !(leave && state_d inside {ERASE_E, PUB_E}));
    valid_p_d = valid_p_q || (state_q == DRAW_P && last);
    valid_e_d = valid_e_q || (state_q == DRAW_E && last);
    lpx_d = start && state_d == DRAW_P ? bus.playerX : lpx_q;
    lpy_d = start && state_d == DRAW_P ? bus.playerY : lpy_q;
    ld_e = start && state_d inside {ERASE_E, DRAW_E};
    ex_d = ld_e ? bus.enemyX : ex_q;
    ey_d = ld_e ? bus.enemyY : ey_q;
    ew_d = ld_e ? bus.enemy_width : ew_q;
    x_d = sx;
    y_d = sy;
    colour_d = state_q == DRAW_P ? (bus.player_hit ? HIT_COLOUR : PLAYER_COLOUR)
             : state_q == DRAW_E ? ENEMY_COLOUR : BG_COLOUR;
    plot_d = is_scan(state_q) && in_bounds;
    busy_d = state_q != IDLE;
    // aligned with the PUB_E state so enemy_control updates before DRAW_E samples
    pos_d = state_d == PUB_E;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pend_p_q <= 1'b0;
      pend_e_q <= 1'b0;
      valid_p_q <= 1'b0;
      valid_e_q <= 1'b0;
      lpx_q <= '0;
      lpy_q <= '0;
      ex_q <= '0;
      ey_q <= '0;
      ew_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_p_q <= pend_p_d;
      pend_e_q <= pend_e_d;
      valid_p_q <= valid_p_d;
      valid_e_q <= valid_e_d;
      lpx_q <= lpx_d;
      lpy_q <= lpy_d;
      ex_q <= ex_d;
      ey_q <= ey_d;
      ew_q <= ew_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      busy_q <= busy_d;
      pos_q <= pos_d;
    end
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.colour = colour_q;
  assign bus.plot = plot_q;
  assign bus.busy = busy_q;
  assign bus.output_pos = pos_q;
endmodule
